ball_dispenser: RTL

Clocked controller for the two ball hoppers at the top of the board. It releases one ball at a time into the left (blue) or right (red) entry. It then waits for that ball to reach a bottom lever, be caught by an interceptor, or time out, and the lever hit selects the colour of the next ball. It sits outside the cell array: its ball outputs feed the top-row cell inputs, and the bottom lever wires and the OR of all interceptor `occupied` flags feed back into it.

---
 rtl/ball_dispenser_if.sv | 27 ++
 rtl/ball_dispenser.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ball_dispenser_if.sv
// Handshake bundle between the ball dispenser and its board-side environment:
// operator controls, lever/interceptor feedback, and release/status outputs.
interface ball_dispenser_if;
  logic       start;
  logic       clear;
  logic       refill;
  logic       i_lever_left;
  logic       i_lever_right;
  logic       i_intercepted;
  logic       o_ball_left;
  logic       o_ball_right;
  logic       busy;
  logic [1:0] halt_reason;
  logic [7:0] blue_left;
  logic [7:0] red_left;
  logic [7:0] released;

  modport master (
    output start, clear, refill, i_lever_left, i_lever_right, i_intercepted,
    input  o_ball_left, o_ball_right, busy, halt_reason, blue_left, red_left, released
  );

  modport slave (
    input  start, clear, refill, i_lever_left, i_lever_right, i_intercepted,
    output o_ball_left, o_ball_right, busy, halt_reason, blue_left, red_left, released
  );
endinterface

// File: rtl/ball_dispenser.sv
// Releases one ball at a time from the blue/red hoppers, then waits for a lever,
// an interception or a timeout; the lever hit picks the colour of the next ball.
module ball_dispenser #(
  parameter int unsigned BLUE_BALLS     = 8,
  parameter int unsigned RED_BALLS      = 8,
  parameter int unsigned PULSE_LEN      = 2,
  parameter int unsigned TRAVEL_TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst,
  ball_dispenser_if.slave   bus
);

  localparam int unsigned CNT_MAX = (PULSE_LEN > TRAVEL_TIMEOUT) ? PULSE_LEN : TRAVEL_TIMEOUT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [1:0] HALT_NONE    = 2'd0;
  localparam logic [1:0] HALT_INTERC  = 2'd1;
  localparam logic [1:0] HALT_EMPTY   = 2'd2;
  localparam logic [1:0] HALT_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {IDLE, RELEASE, IN_FLIGHT, HALTED} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    blue_q, blue_d;
  logic [7:0]    red_q, red_d;
  logic [7:0]    released_q, released_d;
  logic [1:0]    halt_q, halt_d;
  logic          ball_left_q, ball_left_d;
  logic          ball_right_q, ball_right_d;
  logic          busy_q, busy_d;
  logic          lev_l_q, lev_r_q;

  logic          edge_l, edge_r;
  logic [7:0]    blue_avail;
  logic [7:0]    released_inc;

  assign edge_l       = bus.i_lever_left & ~lev_l_q;
  assign edge_r       = bus.i_lever_right & ~lev_r_q;
  assign released_inc = (released_q == 8'hFF) ? released_q : released_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    blue_d       = blue_q;
    red_d        = red_q;
    released_d   = released_q;
    halt_d       = halt_q;
    ball_left_d  = 1'b0;
    ball_right_d = 1'b0;
    blue_avail   = bus.refill ? 8'(BLUE_BALLS) : blue_q;

    case (state_q)
      IDLE: begin
        if (bus.refill) begin
          blue_d = 8'(BLUE_BALLS);
          red_d  = 8'(RED_BALLS);
        end
        // A same-cycle refill is visible to the start through blue_avail.
        if (bus.start) begin
          if (blue_avail != 8'd0) begin
            blue_d      = blue_avail - 8'd1;
            released_d  = released_inc;
            ball_left_d = 1'b1;
            cnt_d       = CW'(1);
            state_d     = RELEASE;
          end else begin
            halt_d  = HALT_EMPTY;
            state_d = HALTED;
          end
        end
      end

      RELEASE: begin
        if (cnt_q >= CW'(PULSE_LEN)) begin
          cnt_d   = '0;
          state_d = IN_FLIGHT;
        end else begin
          cnt_d        = cnt_q + CW'(1);
          ball_left_d  = ball_left_q;
          ball_right_d = ball_right_q;
        end
      end

      IN_FLIGHT: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.i_intercepted) begin
          halt_d  = HALT_INTERC;
          state_d = HALTED;
        end else if (edge_l) begin
          if (blue_q != 8'd0) begin
            blue_d      = blue_q - 8'd1;
            released_d  = released_inc;
            ball_left_d = 1'b1;
            cnt_d       = CW'(1);
            state_d     = RELEASE;
          end else begin
            halt_d  = HALT_EMPTY;
            state_d = HALTED;
          end
        end else if (edge_r) begin
          if (red_q != 8'd0) begin
            red_d        = red_q - 8'd1;
            released_d   = released_inc;
            ball_right_d = 1'b1;
            cnt_d        = CW'(1);
            state_d      = RELEASE;
          end else begin
            halt_d  = HALT_EMPTY;
            state_d = HALTED;
          end
        end else if (cnt_d == CW'(TRAVEL_TIMEOUT)) begin
          halt_d  = HALT_TIMEOUT;
          state_d = HALTED;
        end
      end

      HALTED: begin
        if (bus.refill) begin
          blue_d  = 8'(BLUE_BALLS);
          red_d   = 8'(RED_BALLS);
          halt_d  = HALT_NONE;
          state_d = IDLE;
        end else if (bus.clear) begin
          halt_d  = HALT_NONE;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RELEASE) || (state_d == IN_FLIGHT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      blue_q       <= 8'(BLUE_BALLS);
      red_q        <= 8'(RED_BALLS);
      released_q   <= '0;
      halt_q       <= HALT_NONE;
      ball_left_q  <= 1'b0;
      ball_right_q <= 1'b0;
      busy_q       <= 1'b0;
      lev_l_q      <= 1'b0;
      lev_r_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      blue_q       <= blue_d;
      red_q        <= red_d;
      released_q   <= released_d;
      halt_q       <= halt_d;
      ball_left_q  <= ball_left_d;
      ball_right_q <= ball_right_d;
      busy_q       <= busy_d;
      lev_l_q      <= bus.i_lever_left;
      lev_r_q      <= bus.i_lever_right;
    end
  end

  assign bus.o_ball_left  = ball_left_q;
  assign bus.o_ball_right = ball_right_q;
  assign bus.busy         = busy_q;
  assign bus.halt_reason  = halt_q;
  assign bus.blue_left    = blue_q;
  assign bus.red_left     = red_q;
  assign bus.released     = released_q;

endmodule
